// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - fetch/data arbiter in front of a single shared memory port
module mips_mem_arbiter #(
    parameter int AW            = 9,
    parameter int DW            = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic          busy
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] streak_cnt;
    logic [WW-1:0] wait_cnt;
    logic          grant_if, grant_dm, finish;

    // Data wins ties until it has starved a waiting fetch MAX_DM_STREAK times.
    always_comb begin
        state_n  = state;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && (!if_req || streak_cnt != STREAK_MAX)) begin
                    grant_dm = 1'b1;
                    state_n  = BUSY_DM;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_n  = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack || wait_cnt == WAIT_LAST) begin
                    finish  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            streak_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            // Acks and err are high only for the single RESP cycle.
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
            if (grant_if) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                streak_cnt <= '0;
                wait_cnt   <= '0;
            end else if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                wait_cnt  <= '0;
                if (!if_req) begin
                    streak_cnt <= '0;
                end else if (streak_cnt != STREAK_MAX) begin
                    streak_cnt <= streak_cnt + SW'(1);
                end
            end else if (finish) begin
                mem_req  <= 1'b0;
                wait_cnt <= '0;
                err      <= !mem_ack;
                if (state == BUSY_IF) begin
                    if_ack   <= 1'b1;
                    if_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    dm_ack   <= 1'b1;
                    dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                end
            end else if (state == BUSY_IF || state == BUSY_DM) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - scoreboard bench for mips_mem_arbiter
module tb_mips_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err;
    logic          busy;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DM_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] rdata; logic err; int lat; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } gnt_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    gnt_t gnt_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: acks mem_lat cycles after it first sees mem_req.
    logic [DW-1:0] mem [0:511];
    int  mem_lat = 1;
    int  mcnt = 0;
    bit  stray_pulse = 0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                mcnt = 0;
                if (stray_pulse) begin
                    mem_ack = 1'b1;
                    stray_pulse = 0;
                end
            end else if (mcnt <= mem_lat) begin
                mcnt++;
                if (mcnt == mem_lat + 1) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        mem_rdata = '1;
                    end else begin
                        mem_rdata = mem[mem_addr];
                    end
                end
            end
        end
    end

    int   cyc = 0;
    int   gnt_cyc = 0;
    logic prev_req = 1'b0;
    exp_t me;
    gnt_t mg;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req && !prev_req) begin
                gnt_cyc = cyc;
                if (gnt_q.size() == 0) chk("grant_unexpected", mem_req, 1'b0);
                else begin
                    mg = gnt_q.pop_front();
                    chk("grant_addr", mem_addr, mg.addr);
                    chk("grant_we", mem_we, mg.we);
                    if (mg.we) chk("grant_wdata", mem_wdata, mg.wdata);
                end
            end
            prev_req = mem_req;
            if (if_ack) begin
                if (if_q.size() == 0) chk("if_ack_unexpected", if_ack, 1'b0);
                else begin
                    me = if_q.pop_front();
                    chk("if_rdata", if_rdata, me.rdata);
                    chk("if_err", err, me.err);
                    chk("if_latency", cyc - gnt_cyc, me.lat);
                    chk("if_mem_req_dropped", mem_req, 1'b0);
                end
            end
            if (dm_ack) begin
                if (dm_q.size() == 0) chk("dm_ack_unexpected", dm_ack, 1'b0);
                else begin
                    me = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, me.rdata);
                    chk("dm_err", err, me.err);
                    chk("dm_latency", cyc - gnt_cyc, me.lat);
                    chk("dm_mem_req_dropped", mem_req, 1'b0);
                end
            end
        end
    end

    task automatic do_if(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e,
                         input int lat, input bit pg);
        exp_t x;
        gnt_t g;
        bit   seen = 0;
        x.rdata = d; x.err = e; x.lat = lat;
        if_q.push_back(x);
        if (pg) begin
            g.addr = a; g.we = 1'b0; g.wdata = '0;
            gnt_q.push_back(g);
        end
        if_addr = a;
        if_req = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = if_ack;
        end
        if (!seen) chk("if_ack_timeout", if_ack, 1'b1);
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] d, input logic e, input int lat, input bit pg);
        exp_t x;
        gnt_t g;
        bit   seen = 0;
        x.rdata = d; x.err = e; x.lat = lat;
        dm_q.push_back(x);
        if (pg) begin
            g.addr = a; g.we = we; g.wdata = wd;
            gnt_q.push_back(g);
        end
        dm_we = we;
        dm_addr = a;
        dm_wdata = wd;
        dm_req = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = dm_ack;
        end
        if (!seen) chk("dm_ack_timeout", dm_ack, 1'b1);
        dm_req = 1'b0;
    endtask

    task automatic push_gnt(input logic [AW-1:0] a);
        gnt_t g;
        g.addr = a; g.we = 1'b0; g.wdata = '0;
        gnt_q.push_back(g);
    endtask

    task automatic check_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_if_ack"}, if_ack, 1'b0);
            chk({tag, "_dm_ack"}, dm_ack, 1'b0);
            chk({tag, "_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_if_ack", if_ack, 1'b0);
        chk("rst_dm_ack", dm_ack, 1'b0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_dm_rdata", dm_rdata, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch, 2-cycle memory.
        mem[4] = 32'h8C01_0000;
        mem_lat = 2;
        do_if(9'h004, 32'h8C01_0000, 1'b0, 3, 1'b1);
        @(negedge clk);
        chk("idle_after_fetch", busy, 1'b0);

        // Store then load back, 1-cycle memory.
        mem_lat = 1;
        do_dm(1'b1, 9'h1F0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1);
        do_dm(1'b0, 9'h1F0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
        do_dm(1'b0, 9'h020, 32'h0, 32'h1000_0020, 1'b0, 2, 1'b1);

        // Contention: expected grant order DM x4, IF, DM x4, IF, DM.
        for (int k = 0; k < 4; k++) push_gnt(9'h100 + 9'(k));
        push_gnt(9'h040);
        for (int k = 4; k < 8; k++) push_gnt(9'h100 + 9'(k));
        push_gnt(9'h044);
        push_gnt(9'h108);
        fork
            begin
                do_if(9'h040, 32'h1000_0040, 1'b0, 2, 1'b0);
                do_if(9'h044, 32'h1000_0044, 1'b0, 2, 1'b0);
            end
            begin
                for (int k = 0; k < 9; k++)
                    do_dm(1'b0, 9'h100 + 9'(k), 32'h0, 32'h1000_0100 + k, 1'b0, 2, 1'b0);
            end
        join
        chk("contention_grants_left", gnt_q.size(), 0);
        @(negedge clk);

        // Timeout: memory never answers.
        mem_lat = 1000;
        do_dm(1'b0, 9'h0AA, 32'h0, 32'h0, 1'b1, 16, 1'b1);
        stray_pulse = 1;
        check_quiet("stray_after_timeout", 4);

        // Reset in the middle of a fetch.
        push_gnt(9'h0C0);
        if_addr = 9'h0C0;
        if_req = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("abort_fetch_started", mem_req, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_mem_req", mem_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_if_ack", if_ack, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stray_pulse = 1;
        check_quiet("after_reset", 3);
        mem_lat = 2;
        do_if(9'h0C4, 32'h1000_00C4, 1'b0, 3, 1'b1);

        repeat (2) @(negedge clk);
        chk("if_q_empty", if_q.size(), 0);
        chk("dm_q_empty", dm_q.size(), 0);
        chk("gnt_q_empty", gnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 9, address width; DW, 32, data width; MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits; TIMEOUT, 16, cycles to wait for mem_ack before aborting.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 resets immediately, independent of clk.
REQ-004 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-005 if_addr  input  AW  fetch address, stable while if_req is high.
REQ-006 if_ack  output  1  one-cycle pulse that completes a fetch.
REQ-007 if_rdata  output  DW  fetch data, valid while if_ack is high.
REQ-008 dm_req, dm_we  input  1 each  data-memory request and write enable, held until dm_ack.
REQ-009 dm_addr  input  AW; dm_wdata  input  DW  data-access address and write data, stable while dm_req is high.
REQ-010 dm_ack  output  1  one-cycle completion pulse; dm_rdata  output  DW  load data, valid with dm_ack (0 for stores).
REQ-011 mem_req, mem_we  output  1 each; mem_addr  output  AW; mem_wdata  output  DW  registered request to the single shared memory.
REQ-012 mem_ack  input  1; mem_rdata  input  DW  one-cycle memory completion and read data.
REQ-013 err  output  1  pulses with if_ack or dm_ack when that transaction timed out.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-016 In IDLE, if dm_req and if_req are both low, the FSM SHALL stay in IDLE.
REQ-017 In IDLE with only one request high, the FSM SHALL grant that request.
REQ-018 In IDLE with both requests high, the FSM SHALL grant DM, unless streak_cnt == MAX_DM_STREAK, in which case it SHALL grant IF.
REQ-019 On a grant edge, the FSM SHALL latch the requester's address, we and wdata into mem_* (mem_we is 0 for IF), set mem_req to 1, and enter BUSY_IF or BUSY_DM.
REQ-020 streak_cnt SHALL increment, saturating at MAX_DM_STREAK, on a DM grant made while if_req is high.
REQ-021 streak_cnt SHALL clear on any IF grant and on any DM grant made while if_req is low.
REQ-022 In BUSY_x, mem_req and the mem_* outputs SHALL be held stable, and a wait counter SHALL count from 0.
REQ-023 On mem_ack in BUSY_x, the FSM SHALL register mem_rdata (0 for DM stores), drop mem_req and enter RESP.
REQ-024 If the wait counter reaches TIMEOUT-1 without mem_ack, the FSM SHALL drop mem_req, register rdata = 0, set the error flag and enter RESP.
REQ-025 RESP SHALL last exactly one cycle: it pulses the owner's ack with its rdata (and err if flagged), then returns to IDLE.
REQ-026 A new grant SHALL be possible only from IDLE, so the minimum spacing between consecutive memory requests is 3 cycles (grant, ack, RESP).
REQ-027 Latency from a request sampled in IDLE to its ack SHALL be N+2 cycles, where N is the number of cycles from mem_req rising to mem_ack.
REQ-028 mem_ack received in IDLE or RESP SHALL be ignored.
REQ-029 If a requester drops its req before its ack, the transaction SHALL still complete and ack SHALL still pulse.
REQ-030 rdata outputs SHALL hold their last value outside ack cycles; only the ack-qualified value is defined.
REQ-031 Address arithmetic SHALL be none: addresses pass through unmodified at AW bits.

Reset
REQ-032 While reset == 0: state = IDLE; mem_req, mem_we, if_ack, dm_ack, err and busy = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0; streak_cnt and the wait counter = 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack; a mem_ack arriving after reset releases SHALL be ignored per REQ-028.
REQ-034 The first grant SHALL occur on the first rising edge at which reset is 1 and a req is sampled high.

Verification
REQ-035 Single fetch: if_req=1, if_addr=0x004, memory acks 2 cycles after mem_req with 0x8C010000 -> mem_we=0, mem_addr=0x004; if_ack pulses for 1 cycle with if_rdata=0x8C010000 at request+4 cycles; err=0.
REQ-036 Store: dm_req=1, dm_we=1, dm_addr=0x1F0, dm_wdata=0xDEADBEEF, 1-cycle memory -> mem_we=1, mem_wdata=0xDEADBEEF; dm_ack pulses with dm_rdata=0.
REQ-037 Contention: if_req and dm_req held high continuously with back-to-back DM transactions -> grant order DM,DM,DM,DM,IF,DM... (MAX_DM_STREAK=4); no fetch waits more than 5 grants.
REQ-038 Timeout: dm_req=1, mem_ack never asserted -> mem_req drops after 16 cycles; next cycle dm_ack=1, err=1, dm_rdata=0; FSM returns to IDLE; a later stray mem_ack produces no ack.
REQ-039 Reset mid-operation: reset driven 0 while in BUSY_IF -> mem_req, busy and if_ack fall immediately without a clock edge; no ack after release; the next if_req completes normally.
